dac_sample_fifo: RTL and testbench
==================================

# dac_sample_fifo

Stereo sample buffer sitting directly upstream of the DAC control circuit in the FM-synth audio path. Accepts 16-bit left/right sample pairs from the synthesis engine via a strobe/full handshake and presents one pair on a holding register that the DAC controller captures on its `next` pulse. Decouples the bursty synth engine from the fixed 1-pair-per-2048-clock DAC frame rate; reports fill level and underruns.

## Interface
- `DEPTH_LOG2`, 4, log2 of FIFO depth in sample pairs (depth = 16)
- `clk`  in  1  system clock (same clock as DAC controller)
- `reset`  in  1  synchronous, active-high reset
- `in_l`  in  16  left sample to write, two's complement
- `in_r`  in  16  right sample to write, two's complement
- `in_stb`  in  1  write strobe; pair accepted on a cycle with `in_stb`=1 and `full`=0
- `full`  out  1  FIFO holds DEPTH pairs; writes dropped
- `level`  out  DEPTH_LOG2+1  number of pairs stored (excluding holding register)
- `next`  in  1  one-cycle pulse from DAC controller: current holding pair is consumed
- `sample_l`  out  16  holding register, left
- `sample_r`  out  16  holding register, right
- `underrun`  out  1  one-cycle pulse: `next` arrived with FIFO empty
- `overflow`  out  1  sticky: a write was dropped because `full`=1; cleared only by reset
- `urun_cnt`  out  16  saturating count of underrun events

## Operation
- Storage: circular buffer, DEPTH entries of 32 bits {l, r}; write pointer, read pointer (DEPTH_LOG2 bits, wrap naturally), count register (DEPTH_LOG2+1 bits).
- `full` = (count == DEPTH); empty = (count == 0); both from registered count only.
- Push: `in_stb` && !`full` -> store at wptr, wptr+1.
- Pop: `next` && !empty -> holding register <= entry at rptr, rptr+1.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push and pop same cycle at full: pop occurs, push is dropped (full is registered), `overflow` set.
- Push and pop same cycle at empty: pop fails (underrun), push stored; level becomes 1.
- `next` with empty: `underrun` pulses, `urun_cnt` increments (saturates at 16'hFFFF), holding register per Configuration.
- `in_stb` with `full`: data discarded, no state change except `overflow` <= 1.
- Holding register changes only on `next`; DAC controller sees the pre-update value at that same edge.

## Timing
- Reset values: `sample_l`/`sample_r` 0, `level` 0, `full` 0, `underrun` 0, `overflow` 0, `urun_cnt` 0, pointers 0.
- Reset mid-operation discards all stored pairs; no partial writes survive.
- Write to visible `level`: 1 cycle.
- Write into empty FIFO to holding register: at first subsequent `next` edge; played by the DAC at the second `next`.
- `underrun` asserted the cycle after the `next` edge that found FIFO empty, for exactly one cycle.
- All outputs registered; no combinational path from `in_stb` or `next` to any output.

## Configuration
- `DAC_SAMPLE_FIFO_HOLD_EN` defined: on underrun the holding register keeps its previous value (last sample repeated, avoids clicks).
- Not defined: on underrun the holding register loads 16'h0000/16'h0000 (mute).
- Underrun pulse and counter behave identically in both builds.

## Structure
- Shared package: sample width constant (16), default DEPTH_LOG2, packed stereo-pair type {l, r}.
- One sub-module: `dac_sample_fifo_ram`, simple dual-port storage (1 write port, 1 synchronous-read-free register-array read port), DEPTH x 32; top holds pointers, count, flags, holding register.

## Test plan
- Reset, no writes, pulse `next` 3 times -> 3 `underrun` pulses, `urun_cnt`=3, `sample_l`/`sample_r`=0 in both builds.
- Write pairs (16'h1234,16'h8001),(16'h7FFF,16'h0001); pulse `next` twice -> holding = first pair after first pulse, second pair after second, `level` 2->1->0, no underrun.
- Write 17 pairs back-to-back -> `full`=1 after 16th, `level`=16, 17th dropped, `overflow`=1; drain 16 via `next` -> values in write order, 17th never appears.
- At `level`=16 assert `in_stb` and `next` same cycle -> `level`=15, `overflow`=1; at `level`=0 same -> `underrun` pulse, `level`=1.
- Load 16'h4000 pair, pop it, pulse `next` on empty -> HOLD_EN build: holding stays 16'h4000; other build: 0.
- Force `urun_cnt` to 16'hFFFE via 65534 underruns (or fast-forward), 3 more -> stays 16'hFFFF.

Source files
------------

// File: rtl/dac_sample_fifo_pkg.sv
// Shared types and constants for the DAC stereo sample FIFO.
// Holds the sample width, the default depth and the packed {l, r} pair type.
package dac_sample_fifo_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int PAIR_W         = 2 * SAMPLE_W;
  localparam int DEPTH_LOG2_DEF = 4;

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } stereo_t;

endpackage

// File: rtl/dac_sample_fifo_ram.sv
// Simple dual-port pair storage: one clocked write port, one combinational
// read port from a register array, DEPTH x 32 bits.
module dac_sample_fifo_ram
  import dac_sample_fifo_pkg::*;
#(
  parameter int ADDR_W = DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  stereo_t           i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output stereo_t           o_rdata
);

  stereo_t r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dac_sample_fifo.sv
// Stereo sample FIFO feeding the DAC holding register, with level/underrun/overflow status.
// Define DAC_SAMPLE_FIFO_HOLD_EN to repeat the last pair on underrun instead of muting.
module dac_sample_fifo
  import dac_sample_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SAMPLE_W-1:0]   in_l,
  input  logic [SAMPLE_W-1:0]   in_r,
  input  logic                  in_stb,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  next,
  output logic [SAMPLE_W-1:0]   sample_l,
  output logic [SAMPLE_W-1:0]   sample_r,
  output logic                  underrun,
  output logic                  overflow,
  output logic [15:0]           urun_cnt
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  stereo_t               r_hold;
  logic                  r_underrun;
  logic                  r_overflow;
  logic [15:0]           r_urun_cnt;

  logic    w_full;
  logic    w_empty;
  logic    w_push;
  logic    w_pop;
  stereo_t w_wdata;
  stereo_t w_rdata;

  // Flags come from the registered count only, so a same-cycle pop never frees room for a push.
  assign w_full  = (r_count == DEPTH_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = in_stb && !w_full;
  assign w_pop   = next && !w_empty;
  assign w_wdata = '{l: in_l, r: in_r};

  dac_sample_fifo_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_hold     <= '0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
      r_urun_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + DEPTH_LOG2'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_hold <= w_rdata;
      end else if (next) begin
`ifdef DAC_SAMPLE_FIFO_HOLD_EN
        r_hold <= r_hold;
`else
        r_hold <= '0;
`endif
      end

      r_underrun <= next && w_empty;
      if (next && w_empty && (r_urun_cnt != 16'hFFFF)) begin
        r_urun_cnt <= r_urun_cnt + 16'd1;
      end

      if (in_stb && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign full     = w_full;
  assign level    = r_count;
  assign sample_l = r_hold.l;
  assign sample_r = r_hold.r;
  assign underrun = r_underrun;
  assign overflow = r_overflow;
  assign urun_cnt = r_urun_cnt;

endmodule

// File: tb/tb_dac_sample_fifo.sv
// Directed self-checking bench for dac_sample_fifo; expectations follow the
// DAC_SAMPLE_FIFO_HOLD_EN setting of the build.
module tb_dac_sample_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_l;
  logic [15:0] in_r;
  logic        in_stb;
  logic        full;
  logic [4:0]  level;
  logic        next;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        underrun;
  logic        overflow;
  logic [15:0] urun_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  dac_sample_fifo #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_l     (in_l),
    .in_r     (in_r),
    .in_stb   (in_stb),
    .full     (full),
    .level    (level),
    .next     (next),
    .sample_l (sample_l),
    .sample_r (sample_r),
    .underrun (underrun),
    .overflow (overflow),
    .urun_cnt (urun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_stb = 1'b0; next = 1'b0; in_l = '0; in_r = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    in_l = l; in_r = r; in_stb = 1'b1;
    tick();
    in_stb = 1'b0;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    tick();
    next = 1'b0;
  endtask

  logic [15:0] mute_or_hold;

  initial begin
    do_reset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_urun_cnt", 32'(urun_cnt), 32'd0);
    chk("rst_sample", {sample_l, sample_r}, 32'h0);

    // three underruns on an empty FIFO
    for (int i = 0; i < 3; i++) begin
      pulse_next();
      chk($sformatf("urun%0d_pulse", i), 32'(underrun), 32'd1);
      tick();
      chk($sformatf("urun%0d_low", i), 32'(underrun), 32'd0);
    end
    chk("urun_cnt3", 32'(urun_cnt), 32'd3);
    chk("urun_sample", {sample_l, sample_r}, 32'h0);

    // two pairs through the holding register
    push(16'h1234, 16'h8001);
    chk("lvl_after_w1", 32'(level), 32'd1);
    chk("hold_unchanged_on_write", {sample_l, sample_r}, 32'h0);
    push(16'h7FFF, 16'h0001);
    chk("lvl_after_w2", 32'(level), 32'd2);
    pulse_next();
    chk("pop1_sample", {sample_l, sample_r}, 32'h1234_8001);
    chk("pop1_level", 32'(level), 32'd1);
    chk("pop1_underrun", 32'(underrun), 32'd0);
    pulse_next();
    chk("pop2_sample", {sample_l, sample_r}, 32'h7FFF_0001);
    chk("pop2_level", 32'(level), 32'd0);
    chk("pop2_underrun", 32'(underrun), 32'd0);

    // 17 writes: 16 stored, the 17th dropped
    for (int i = 0; i < 17; i++) begin
      push(16'h0100 + 16'(i), 16'hA000 + 16'(i));
      if (i == 15) begin
        chk("fill16_full", 32'(full), 32'd1);
        chk("fill16_level", 32'(level), 32'd16);
        chk("fill16_overflow", 32'(overflow), 32'd0);
      end
    end
    chk("w17_level", 32'(level), 32'd16);
    chk("w17_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      pulse_next();
      chk($sformatf("drain%0d", i), {sample_l, sample_r}, {16'h0100 + 16'(i), 16'hA000 + 16'(i)});
    end
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_full", 32'(full), 32'd0);
    pulse_next();
`ifdef DAC_SAMPLE_FIFO_HOLD_EN
    mute_or_hold = 16'h010F;
`else
    mute_or_hold = 16'h0000;
`endif
    chk("after17_underrun", 32'(underrun), 32'd1);
    chk("after17_sample_l", 32'(sample_l), 32'(mute_or_hold));
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // reset mid-operation discards contents and clears the sticky flag
    push(16'h5555, 16'h6666);
    do_reset();
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    chk("midrst_sample", {sample_l, sample_r}, 32'h0);

    // push and pop together at full
    for (int i = 0; i < 16; i++) push(16'h0200 + 16'(i), 16'h0300 + 16'(i));
    in_l = 16'hDEAD; in_r = 16'hBEEF; in_stb = 1'b1; next = 1'b1;
    tick();
    in_stb = 1'b0; next = 1'b0;
    chk("fullboth_level", 32'(level), 32'd15);
    chk("fullboth_overflow", 32'(overflow), 32'd1);
    chk("fullboth_sample", {sample_l, sample_r}, 32'h0200_0300);

    // push and pop together at empty
    do_reset();
    in_l = 16'h2222; in_r = 16'h3333; in_stb = 1'b1; next = 1'b1;
    tick();
    in_stb = 1'b0; next = 1'b0;
    chk("emptyboth_underrun", 32'(underrun), 32'd1);
    chk("emptyboth_level", 32'(level), 32'd1);
    chk("emptyboth_cnt", 32'(urun_cnt), 32'd1);
    pulse_next();
    chk("emptyboth_pop", {sample_l, sample_r}, 32'h2222_3333);

    // hold versus mute on underrun
    do_reset();
    push(16'h4000, 16'h4000);
    pulse_next();
    chk("hold_pop", {sample_l, sample_r}, 32'h4000_4000);
    pulse_next();
`ifdef DAC_SAMPLE_FIFO_HOLD_EN
    mute_or_hold = 16'h4000;
`else
    mute_or_hold = 16'h0000;
`endif
    chk("hold_urun_l", 32'(sample_l), 32'(mute_or_hold));
    chk("hold_urun_r", 32'(sample_r), 32'(mute_or_hold));
    chk("hold_urun_pulse", 32'(underrun), 32'd1);

    // counter saturation: next held high on an empty FIFO underruns every cycle
    do_reset();
    next = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", 32'(urun_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) tick();
    next = 1'b0;
    chk("sat_ffff", 32'(urun_cnt), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(urun_cnt), 32'hFFFF);
    chk("sat_pulse_low", 32'(underrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
